// File: rtl/i2c_regs_pkg.sv
// Register map, field positions and address decode shared by the I2C APB
// register file and its interrupt controller.
package i2c_regs_pkg;

  localparam logic [7:0] OFF_CR       = 8'h00;
  localparam logic [7:0] OFF_SR       = 8'h04;
  localparam logic [7:0] OFF_TXFIFO   = 8'h08;
  localparam logic [7:0] OFF_RXFIFO   = 8'h0C;
  localparam logic [7:0] OFF_SLVADR   = 8'h10;
  localparam logic [7:0] OFF_TXOCY    = 8'h14;
  localparam logic [7:0] OFF_RXOCY    = 8'h18;
  localparam logic [7:0] OFF_RXPIRQ   = 8'h1C;
  localparam logic [7:0] OFF_ISR      = 8'h20;
  localparam logic [7:0] OFF_IER      = 8'h24;
  localparam logic [7:0] OFF_GIE      = 8'h28;
  localparam logic [7:0] OFF_SOFTR    = 8'h2C;
  localparam logic [7:0] OFF_DEBOUNCE = 8'h30;
  localparam logic [7:0] OFF_TSUSTA   = 8'h34;
  localparam logic [7:0] OFF_TBUF     = 8'h50;

  localparam logic [31:0] SOFTR_KEY = 32'h0000_000A;
  localparam int NUM_TIM = 8;

  localparam int CR_EN         = 0;
  localparam int CR_TXFIFO_RST = 1;
  localparam int CR_MSMS       = 2;
  localparam int CR_TX         = 3;
  localparam int CR_TXAK       = 4;
  localparam int CR_RSTA       = 5;
  localparam int CR_GCEN       = 6;

  localparam int SR_TX_FULL  = 4;
  localparam int SR_RX_EMPTY = 6;

  typedef enum logic [3:0] {
    REG_NONE, REG_CR, REG_SR, REG_TXFIFO, REG_RXFIFO, REG_SLVADR, REG_TXOCY,
    REG_RXOCY, REG_RXPIRQ, REG_ISR, REG_IER, REG_GIE, REG_SOFTR, REG_DEBOUNCE,
    REG_TIM
  } reg_e;

  // Takes the word address (paddr[7:2]); the eight timing registers share one code.
  function automatic reg_e decode_reg(input logic [5:0] word);
    logic [7:0] a;
    a = {word, 2'b00};
    if (a >= OFF_TSUSTA && a <= OFF_TBUF) return REG_TIM;
    case (a)
      OFF_CR:       return REG_CR;
      OFF_SR:       return REG_SR;
      OFF_TXFIFO:   return REG_TXFIFO;
      OFF_RXFIFO:   return REG_RXFIFO;
      OFF_SLVADR:   return REG_SLVADR;
      OFF_TXOCY:    return REG_TXOCY;
      OFF_RXOCY:    return REG_RXOCY;
      OFF_RXPIRQ:   return REG_RXPIRQ;
      OFF_ISR:      return REG_ISR;
      OFF_IER:      return REG_IER;
      OFF_GIE:      return REG_GIE;
      OFF_SOFTR:    return REG_SOFTR;
      OFF_DEBOUNCE: return REG_DEBOUNCE;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_apb_regs_if.sv
// APB3 bus bundle between the CPU-side master and the I2C register file.
interface i2c_apb_regs_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/i2c_irq_ctrl.sv
// Rising-edge capture of core interrupt requests into a W1C status register,
// with per-source enables, a global enable and one registered interrupt line.
module i2c_irq_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] irq_req,
  input  logic       soft_clr,
  input  logic [7:0] isr_clr,
  input  logic       ier_we,
  input  logic [7:0] ier_wdata,
  input  logic       gie_we,
  input  logic       gie_wdata,
  output logic [7:0] isr,
  output logic [7:0] ier,
  output logic       gie,
  output logic       irq
);

  logic [7:0] prev_q, prev_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] ier_q, ier_d;
  logic       gie_q, gie_d;
  logic       irq_q, irq_d;

  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    prev_d = irq_req;
    isr_d  = (isr_q & ~isr_clr) | (irq_req & ~prev_q);
    ier_d  = ier_q;
    gie_d  = gie_q;
    if (soft_clr) begin
      ier_d = '0;
      gie_d = 1'b0;
    end else begin
      if (ier_we) ier_d = ier_wdata;
      if (gie_we) gie_d = gie_wdata;
    end
    irq_d = gie_q & |(isr_q & ier_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      prev_q <= '0;
      isr_q  <= '0;
      ier_q  <= '0;
      gie_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      isr_q  <= isr_d;
      ier_q  <= ier_d;
      gie_q  <= gie_d;
      irq_q  <= irq_d;
    end
  end

  assign isr = isr_q;
  assign ier = ier_q;
  assign gie = gie_q;
  assign irq = irq_q;

endmodule

// File: rtl/i2c_apb_regs.sv
// APB3 register file in front of i2c_core: control/timing registers, FIFO
// push/pop strobes, interrupt status and a counted soft reset of the core.
module i2c_apb_regs
  import i2c_regs_pkg::*;
#(
  parameter int unsigned SOFTR_CYC = 16,
  parameter int unsigned DEF_TLOW  = 500,
  parameter int unsigned DEF_THIGH = 500,
  parameter int unsigned DEF_TDAT  = 25,
  parameter int unsigned DEF_DEB   = 10
) (
  input  logic              clk,
  input  logic              rstn,
  i2c_apb_regs_if.slave     apb,
  output logic [7:0]        cr,
  output logic              cr_msms,
  output logic [9:0]        slv_adr,
  input  logic [7:0]        sr,
  input  logic [7:0]        irq_req,
  output logic              tx_fifo_wr,
  output logic [9:0]        tx_fifo_din,
  input  logic [4:0]        tx_fifo_ocy,
  output logic              rx_fifo_rd,
  input  logic [7:0]        rx_fifo_dout,
  input  logic [4:0]        rx_fifo_ocy,
  output logic [4:0]        rx_fifo_pirq,
  output logic [13:0]       debounct_cnt,
  output logic [31:0]       tsusta,
  output logic [31:0]       thdsta,
  output logic [31:0]       tsusto,
  output logic [31:0]       tsudat,
  output logic [31:0]       thddat,
  output logic [31:0]       tlow,
  output logic [31:0]       thigh,
  output logic [31:0]       tbuf,
  output logic              core_rstn,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(SOFTR_CYC + 1);

  // Timing slots in address order: TSUSTA THDSTA TSUSTO TSUDAT THDDAT TLOW THIGH TBUF.
  function automatic logic [31:0] tim_default(input int idx);
    case (idx)
      1, 6:    return 32'(DEF_THIGH);
      3, 4:    return 32'(DEF_TDAT);
      default: return 32'(DEF_TLOW);
    endcase
  endfunction

  logic [7:0]       cr_q, cr_d;
  logic [9:0]       slvadr_q, slvadr_d;
  logic [4:0]       rxpirq_q, rxpirq_d;
  logic [13:0]      deb_q, deb_d;
  logic [31:0]      tim_q [NUM_TIM];
  logic [31:0]      tim_d [NUM_TIM];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pslverr_q, pslverr_d;
  logic             tx_wr_q, tx_wr_d;
  logic [9:0]       tx_din_q, tx_din_d;
  logic             rx_rd_q, rx_rd_d;

  logic        setup, access, busy, wr_ok, err, soft_clr;
  reg_e        sel;
  logic [2:0]  tim_idx;
  logic [31:0] rdata;
  logic [7:0]  isr, ier, isr_clr;
  logic        gie;
  logic        unused_paddr_lsb;

  assign setup            = apb.psel & ~apb.penable;
  assign access           = apb.psel & apb.penable;
  assign sel              = decode_reg(apb.paddr[7:2]);
  assign tim_idx          = apb.paddr[4:2] - 3'd5;
  assign busy             = (cnt_q != '0);
  assign unused_paddr_lsb = ^apb.paddr[1:0];
  // The error verdict is taken in setup and carried into the access phase.
  assign wr_ok            = access & apb.pwrite & ~pslverr_q;

  always_comb begin
    err = 1'b0;
    if (sel == REG_NONE)        err = 1'b1;
    else if (apb.pwrite) begin
      if (sel == REG_SOFTR)     err = (apb.pwdata != SOFTR_KEY);
      else                      err = busy || (sel == REG_TXFIFO && sr[SR_TX_FULL]);
    end else                    err = (sel == REG_RXFIFO) && sr[SR_RX_EMPTY];
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CR:       rdata = {24'b0, cr_q};
      REG_SR:       rdata = {24'b0, sr};
      REG_RXFIFO:   rdata = {24'b0, rx_fifo_dout};
      REG_SLVADR:   rdata = {22'b0, slvadr_q};
      REG_TXOCY:    rdata = {27'b0, tx_fifo_ocy};
      REG_RXOCY:    rdata = {27'b0, rx_fifo_ocy};
      REG_RXPIRQ:   rdata = {27'b0, rxpirq_q};
      REG_ISR:      rdata = {24'b0, isr};
      REG_IER:      rdata = {24'b0, ier};
      REG_GIE:      rdata = {31'b0, gie};
      REG_DEBOUNCE: rdata = {18'b0, deb_q};
      REG_TIM:      rdata = tim_q[tim_idx];
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    cr_d                = cr_q;
    cr_d[CR_TXFIFO_RST] = 1'b0;
    slvadr_d            = slvadr_q;
    rxpirq_d            = rxpirq_q;
    deb_d               = deb_q;
    tim_d               = tim_q;
    cnt_d               = busy ? cnt_q - CNT_W'(1) : cnt_q;
    tx_wr_d             = 1'b0;
    tx_din_d            = tx_din_q;
    rx_rd_d             = access & ~apb.pwrite & ~pslverr_q & (sel == REG_RXFIFO);
    soft_clr            = 1'b0;
    if (wr_ok) begin
      case (sel)
        REG_CR:       cr_d = apb.pwdata[7:0];
        REG_SLVADR:   slvadr_d = apb.pwdata[9:0];
        REG_RXPIRQ:   rxpirq_d = apb.pwdata[4:0];
        REG_DEBOUNCE: deb_d = apb.pwdata[13:0];
        REG_TIM:      tim_d[tim_idx] = apb.pwdata;
        REG_TXFIFO: begin
          tx_wr_d  = 1'b1;
          tx_din_d = apb.pwdata[9:0];
        end
        REG_SOFTR: begin
          soft_clr = 1'b1;
          cnt_d    = CNT_W'(SOFTR_CYC);
          cr_d     = '0;
          slvadr_d = '0;
          rxpirq_d = '0;
          deb_d    = 14'(DEF_DEB);
          for (int i = 0; i < NUM_TIM; i++) tim_d[i] = tim_default(i);
        end
        default: ;
      endcase
    end
    prdata_d  = setup ? (err ? '0 : rdata) : prdata_q;
    pslverr_d = setup ? err : (access & pslverr_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cr_q      <= '0;
      slvadr_q  <= '0;
      rxpirq_q  <= '0;
      deb_q     <= 14'(DEF_DEB);
      // NOTE: the timing array holds configuration, so each entry is reset explicitly.
      for (int i = 0; i < NUM_TIM; i++) tim_q[i] <= tim_default(i);
      cnt_q     <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_din_q  <= '0;
      rx_rd_q   <= 1'b0;
    end else begin
      cr_q      <= cr_d;
      slvadr_q  <= slvadr_d;
      rxpirq_q  <= rxpirq_d;
      deb_q     <= deb_d;
      tim_q     <= tim_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      tx_wr_q   <= tx_wr_d;
      tx_din_q  <= tx_din_d;
      rx_rd_q   <= rx_rd_d;
    end
  end

  assign isr_clr = (wr_ok && sel == REG_ISR) ? apb.pwdata[7:0] : '0;

  i2c_irq_ctrl u_irq_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .irq_req   (irq_req),
    .soft_clr  (soft_clr),
    .isr_clr   (isr_clr),
    .ier_we    (wr_ok && sel == REG_IER),
    .ier_wdata (apb.pwdata[7:0]),
    .gie_we    (wr_ok && sel == REG_GIE),
    .gie_wdata (apb.pwdata[0]),
    .isr       (isr),
    .ier       (ier),
    .gie       (gie),
    .irq       (irq)
  );

  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;
  assign apb.pready  = 1'b1;

  assign cr           = cr_q;
  assign cr_msms      = cr_q[CR_MSMS];
  assign slv_adr      = slvadr_q;
  assign tx_fifo_wr   = tx_wr_q;
  assign tx_fifo_din  = tx_din_q;
  assign rx_fifo_rd   = rx_rd_q;
  assign rx_fifo_pirq = rxpirq_q;
  assign debounct_cnt = deb_q;
  assign tsusta       = tim_q[0];
  assign thdsta       = tim_q[1];
  assign tsusto       = tim_q[2];
  assign tsudat       = tim_q[3];
  assign thddat       = tim_q[4];
  assign tlow         = tim_q[5];
  assign thigh        = tim_q[6];
  assign tbuf         = tim_q[7];
  assign core_rstn    = rstn & ~busy;

endmodule
